// File: rtl/irq_controller_if.sv
// Signal bundle between irq_controller (slave) and the core/trap logic (master).
interface irq_controller_if #(
  parameter int unsigned NUM_SRC = 4
);
  logic [NUM_SRC-1:0] irq_in;
  logic [NUM_SRC-1:0] irq_en;
  logic [31:0]        pc_address;
  logic               trap_ack;
  logic               mret;
  logic               trap_req;
  logic [31:0]        trap_vector;
  logic [3:0]         trap_cause;
  logic [31:0]        mepc;
  logic               in_handler;

  modport master (
    output irq_in, irq_en, pc_address, trap_ack, mret,
    input  trap_req, trap_vector, trap_cause, mepc, in_handler
  );

  modport slave (
    input  irq_in, irq_en, pc_address, trap_ack, mret,
    output trap_req, trap_vector, trap_cause, mepc, in_handler
  );
endinterface

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller: lowest-index priority, single trap in flight.
// Define IRQ_VECTORED_EN for vectored mode (MTVEC_BASE + 4*cause); otherwise direct mode.
module irq_controller #(
  parameter int unsigned NUM_SRC    = 4,
  parameter logic [31:0] MTVEC_BASE = 32'h1000
) (
  input logic             clk,
  input logic             rst,
  irq_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, HANDLER} state_e;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] rise, active, clr;
  logic [3:0]         cause_q, cause_d, lowest;
  logic [31:0]        vector_q, vector_d;
  logic [31:0]        mepc_q, mepc_d;
  logic               found;

  assign rise   = bus.irq_in & ~irq_q;
  assign active = pending_q & bus.irq_en;

  always_comb begin
    lowest = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (active[i] && !found) begin
        lowest = 4'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    vector_d = vector_q;
    mepc_d   = mepc_q;
    clr      = '0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = REQ;
          cause_d = lowest;
          mepc_d  = bus.pc_address;
`ifdef IRQ_VECTORED_EN
          vector_d = MTVEC_BASE + {26'b0, lowest, 2'b00};
`else
          vector_d = MTVEC_BASE;
`endif
        end
      end
      REQ: begin
        if (bus.trap_ack) begin
          state_d = HANDLER;
          for (int unsigned i = 0; i < NUM_SRC; i++) begin
            clr[i] = (cause_q == 4'(i));
          end
        end
      end
      HANDLER: begin
        if (bus.mret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge on the source being acknowledged re-arms it in the same cycle.
    pending_d = (pending_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      cause_q   <= '0;
      vector_q  <= '0;
      mepc_q    <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= bus.irq_in;
      pending_q <= pending_d;
      cause_q   <= cause_d;
      vector_q  <= vector_d;
      mepc_q    <= mepc_d;
    end
  end

  assign bus.trap_req    = (state_q == REQ);
  assign bus.in_handler  = (state_q == HANDLER);
  assign bus.trap_cause  = cause_q;
  assign bus.trap_vector = vector_q;
  assign bus.mepc        = mepc_q;

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have a parameter NUM_SRC, default 4, giving the number of interrupt sources (range 2..16).
REQ-002 The block SHALL have a parameter MTVEC_BASE, default 32'h1000, giving the trap base address.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port irq_in, input, NUM_SRC bits: level interrupt lines; a rising edge makes a source pending.
REQ-006 The block SHALL have port irq_en, input, NUM_SRC bits: per-source enable mask.
REQ-007 The block SHALL have port pc_address, input, 32 bits: PC of the instruction to resume.
REQ-008 The block SHALL have port trap_ack, input, 1 bit: the core accepts the trap.
REQ-009 The block SHALL have port mret, input, 1 bit: the handler returns.
REQ-010 The block SHALL have port trap_req, output, 1 bit: trap request to the core.
REQ-011 The block SHALL have port trap_vector, output, 32 bits: handler address.
REQ-012 The block SHALL have port trap_cause, output, 4 bits: index of the source being serviced.
REQ-013 The block SHALL have port mepc, output, 32 bits: saved return PC.
REQ-014 The block SHALL have port in_handler, output, 1 bit: high while in state HANDLER.

Function
REQ-015 The block SHALL register irq_in each cycle and set pending[i] when irq_in[i]=1 and its previous sample was 0.
REQ-016 The block SHALL use a state machine with three states: IDLE, REQ and HANDLER.
REQ-017 In IDLE, when (pending & irq_en) is nonzero, the block SHALL move to REQ on the next edge, and on that edge:
- latch trap_cause as the lowest set index;
- latch mepc from pc_address;
- latch trap_vector.
REQ-018 In REQ, trap_req SHALL be 1, and trap_cause, trap_vector and mepc SHALL be held stable until trap_ack.
REQ-019 In REQ, trap_ack SHALL move the block to HANDLER and clear pending[trap_cause] on the same edge.
REQ-020 If pending[trap_cause] is cleared and a new rising edge on the same source occurs in the same cycle, the set SHALL win.
REQ-021 In HANDLER, trap_req SHALL be 0 and no new trap SHALL be taken; pending bits SHALL continue to accumulate.
REQ-022 In HANDLER, mret SHALL return the block to IDLE, and any remaining enabled pending source SHALL then be taken one cycle later (no back-to-back REQ).
REQ-023 mret outside HANDLER and trap_ack outside REQ SHALL be ignored.
REQ-024 Clearing irq_en[trap_cause] while in REQ SHALL NOT withdraw the request.
REQ-025 Latency from the rising edge on irq_in to trap_req=1 SHALL be 2 cycles: one cycle for edge capture, one for IDLE to REQ.

Reset
REQ-026 When rst is asserted, the block SHALL immediately set:
- state to IDLE;
- pending and the irq_in history to 0;
- trap_req, in_handler, trap_cause, trap_vector and mepc to 0.
REQ-027 When rst is asserted mid-REQ or mid-HANDLER, the block SHALL abandon the trap with no request pending after release.

Configuration
REQ-028 With macro IRQ_VECTORED_EN defined, trap_vector SHALL equal MTVEC_BASE + 4*trap_cause.
REQ-029 Without IRQ_VECTORED_EN, trap_vector SHALL equal MTVEC_BASE for every cause.

Verification
REQ-030 The bench SHALL check single-source service:
- stimulus: irq_en=4'hF, rising edge on irq_in[2], pc_address=32'h200;
- required response: 2 cycles later trap_req=1, trap_cause=2, mepc=32'h200, trap_vector=32'h1008 (vectored) or 32'h1000 (direct).
REQ-031 The bench SHALL check priority:
- stimulus: irq_in[3] and irq_in[1] rise together;
- required response: cause=1 is serviced first; after trap_ack and mret, cause=3 is serviced without a new edge.
REQ-032 The bench SHALL check the hold-until-ack rule:
- stimulus: trap_ack held low for 5 cycles;
- required response: trap_req and all outputs stay constant; ack in cycle 6 gives in_handler=1 and trap_req=0 the next cycle.
REQ-033 The bench SHALL check masking in the handler:
- stimulus: irq_in[0] rises while in HANDLER;
- required response: no trap_req until mret; then trap_req=1 with cause=0.
REQ-034 The bench SHALL check the enable mask:
- stimulus: irq_en=4'b1110, rising edge on irq_in[0];
- required response: no trap; setting irq_en[0]=1 later triggers trap_req 1 cycle after.
REQ-035 The bench SHALL check reset mid-REQ:
- stimulus: assert rst while trap_req=1;
- required response: all outputs read 0 asynchronously and stay in IDLE after release.
